hazard_bypass_unit: RTL and testbench

Parametrised successor to the pipeline's operand forwarding logic. It resolves RAW hazards for NREAD decode-stage read ports against NSTAGE downstream write-back sources, plus a dedicated long-latency (multi-cycle mul/div) completion port. It keeps a registered scoreboard of destinations owned by in-flight long-latency operations and generates the decode stall. It sits between the register file read in DEC and the EXE input registers, and it drives the pipeline's global stall.

---
 rtl/hazard_bypass_unit_if.sv | 38 +++
 rtl/hazard_bypass_unit.sv | 84 ++++++++
 tb/tb_hazard_bypass_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_bypass_unit_if.sv
// Decode-side operand/bypass bus of the hazard bypass unit.
// The master drives decode, stage and long-latency inputs. The slave (the unit) returns operands, stall and scoreboard state.
interface hazard_bypass_unit_if #(
    parameter int XLEN   = 32,
    parameter int NREAD  = 2,
    parameter int NSTAGE = 2,
    parameter int CNTW   = 32
);
    logic [NREAD*5-1:0]     addrDEC;
    logic [NREAD*XLEN-1:0]  rsDEC;
    logic [NREAD-1:0]       useDEC;
    logic [4:0]             rdDEC;
    logic                   WregDEC;
    logic                   issueLongDEC;
    logic [NSTAGE*5-1:0]    rdS;
    logic [NSTAGE*XLEN-1:0] dataS;
    logic [NSTAGE-1:0]      WregS;
    logic [NSTAGE-1:0]      readyS;
    logic                   doneLong;
    logic [4:0]             rdLong;
    logic [XLEN-1:0]        dataLong;
    logic [NREAD*XLEN-1:0]  rsF;
    logic                   stall;
    logic [31:0]            pending;
    logic [CNTW-1:0]        stallCount;

    modport master (
        output addrDEC, rsDEC, useDEC, rdDEC, WregDEC, issueLongDEC,
        output rdS, dataS, WregS, readyS, doneLong, rdLong, dataLong,
        input  rsF, stall, pending, stallCount
    );

    modport slave (
        input  addrDEC, rsDEC, useDEC, rdDEC, WregDEC, issueLongDEC,
        input  rdS, dataS, WregS, readyS, doneLong, rdLong, dataLong,
        output rsF, stall, pending, stallCount
    );
endinterface

// File: rtl/hazard_bypass_unit.sv
// RAW operand forwarding across NSTAGE write-back sources plus a long-latency completion port.
// Also keeps the long-op destination scoreboard and generates the decode stall.
module hazard_bypass_unit #(
    parameter int XLEN   = 32,
    parameter int NREAD  = 2,
    parameter int NSTAGE = 2,
    parameter int CNTW   = 32
) (
    input logic clock,
    input logic reset,
    hazard_bypass_unit_if.slave bus
);
    logic [31:0]            pending_q;
    logic [31:0]            pending_d;
    logic [CNTW-1:0]        stall_cnt_q;
    logic [NREAD*XLEN-1:0]  rsf_v;
    logic [NREAD-1:0]       haz;
    logic                   waw;
    logic                   stall_w;
    logic [4:0]             a;
    logic                   found;

    // The first matching stage decides the port's result, even when it is not ready: older stages are never consulted past it.
    always_comb begin
        rsf_v = bus.rsDEC;
        haz   = '0;
        a     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            a     = bus.addrDEC[i*5 +: 5];
            found = 1'b0;
            if (a != 5'd0) begin
                for (int unsigned s = 0; s < NSTAGE; s++) begin
                    if (!found && bus.WregS[s] && (bus.rdS[s*5 +: 5] == a)) begin
                        found = 1'b1;
                        if (bus.readyS[s])
                            rsf_v[i*XLEN +: XLEN] = bus.dataS[s*XLEN +: XLEN];
                        else
                            haz[i] = bus.useDEC[i];
                    end
                end
                if (!found) begin
                    if (bus.doneLong && (bus.rdLong == a))
                        rsf_v[i*XLEN +: XLEN] = bus.dataLong;
                    else if (pending_q[a])
                        haz[i] = bus.useDEC[i];
                end
            end
        end
    end

    always_comb begin
        waw = (bus.WregDEC || bus.issueLongDEC) && (bus.rdDEC != 5'd0)
              && pending_q[bus.rdDEC]
              && !(bus.doneLong && (bus.rdLong == bus.rdDEC));
        stall_w = (|haz) || waw;
    end

    // A clear and a set to the same register in one cycle resolve to set, so the clear is applied first.
    always_comb begin
        pending_d = pending_q;
        if (bus.doneLong)
            pending_d[bus.rdLong] = 1'b0;
        if (bus.issueLongDEC && !stall_w && (bus.rdDEC != 5'd0))
            pending_d[bus.rdDEC] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (stall_w && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
        end
    end

    assign bus.rsF        = rsf_v;
    assign bus.stall      = stall_w;
    assign bus.pending    = pending_q;
    assign bus.stallCount = stall_cnt_q;
endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Directed bench for hazard_bypass_unit: stimulus queues expectations, a negedge monitor compares them.
// A second instance with a 4-bit stall counter shares the stimulus to exercise saturation.
module tb_hazard_bypass_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [9:0]  addrDEC;
  logic [63:0] rsDEC;
  logic [1:0]  useDEC;
  logic [4:0]  rdDEC;
  logic        WregDEC;
  logic        issueLongDEC;
  logic [9:0]  rdS;
  logic [63:0] dataS;
  logic [1:0]  WregS;
  logic [1:0]  readyS;
  logic        doneLong;
  logic [4:0]  rdLong;
  logic [31:0] dataLong;

  hazard_bypass_unit_if #(.XLEN(32), .NREAD(2), .NSTAGE(2), .CNTW(32)) bus ();
  hazard_bypass_unit_if #(.XLEN(32), .NREAD(2), .NSTAGE(2), .CNTW(4))  bus4 ();

  assign bus.addrDEC = addrDEC;           assign bus4.addrDEC = addrDEC;
  assign bus.rsDEC = rsDEC;               assign bus4.rsDEC = rsDEC;
  assign bus.useDEC = useDEC;             assign bus4.useDEC = useDEC;
  assign bus.rdDEC = rdDEC;               assign bus4.rdDEC = rdDEC;
  assign bus.WregDEC = WregDEC;           assign bus4.WregDEC = WregDEC;
  assign bus.issueLongDEC = issueLongDEC; assign bus4.issueLongDEC = issueLongDEC;
  assign bus.rdS = rdS;                   assign bus4.rdS = rdS;
  assign bus.dataS = dataS;               assign bus4.dataS = dataS;
  assign bus.WregS = WregS;               assign bus4.WregS = WregS;
  assign bus.readyS = readyS;             assign bus4.readyS = readyS;
  assign bus.doneLong = doneLong;         assign bus4.doneLong = doneLong;
  assign bus.rdLong = rdLong;             assign bus4.rdLong = rdLong;
  assign bus.dataLong = dataLong;         assign bus4.dataLong = dataLong;

  hazard_bypass_unit #(.XLEN(32), .NREAD(2), .NSTAGE(2), .CNTW(32)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  hazard_bypass_unit #(.XLEN(32), .NREAD(2), .NSTAGE(2), .CNTW(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4)
  );

  typedef struct {
    int unsigned cyc;
    int unsigned sel;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cnt32 = 0;
  int unsigned cnt4 = 0;

  localparam int unsigned RSF0 = 0, RSF1 = 1, STALL = 2, PEND = 3, CNT = 4, CNT4 = 5, STALL4 = 6;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] observe(int unsigned sel);
    case (sel)
      RSF0:    return bus.rsF[31:0];
      RSF1:    return bus.rsF[63:32];
      STALL:   return {31'b0, bus.stall};
      PEND:    return bus.pending;
      CNT:     return bus.stallCount;
      CNT4:    return {28'b0, bus4.stallCount};
      default: return {31'b0, bus4.stall};
    endcase
  endfunction

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] got;
      e   = q.pop_front();
      got = observe(e.sel);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.nm, got, e.exp, cyc);
      end
    end
  end

  task automatic chk(input string nm, input int unsigned sel, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.exp = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_cnt"}, CNT, cnt32);
    chk({nm, "_cnt4"}, CNT4, cnt4);
  endtask

  task automatic adv(input bit stalled);
    @(posedge clock);
    #1;
    if (stalled && !reset) begin
      cnt32++;
      if (cnt4 < 15) cnt4++;
    end
  endtask

  task automatic clr();
    addrDEC = '0; rsDEC = {32'h0B0B0B0B, 32'h0A0A0A0A}; useDEC = '0;
    rdDEC = '0; WregDEC = 1'b0; issueLongDEC = 1'b0;
    rdS = '0; dataS = '0; WregS = '0; readyS = '0;
    doneLong = 1'b0; rdLong = '0; dataLong = '0;
  endtask

  task automatic stg(input int unsigned s, input logic [4:0] rd, input logic w, input logic r, input logic [31:0] d);
    rdS[s*5 +: 5]     = rd;
    WregS[s]          = w;
    readyS[s]         = r;
    dataS[s*32 +: 32] = d;
  endtask

  task automatic prt(input int unsigned i, input logic [4:0] ad, input logic u);
    addrDEC[i*5 +: 5] = ad;
    useDEC[i]         = u;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_stall", STALL, 0); chk("rst_pend", PEND, 0); chk_cnt("rst");
    adv(0);
    reset = 1'b0;

    // stage priority
    clr(); prt(0, 5, 1);
    stg(0, 5, 1, 1, 32'hAAAA0000); stg(1, 5, 1, 1, 32'h11111111);
    chk("prio_rsf0", RSF0, 32'hAAAA0000); chk("prio_stall", STALL, 0);
    #1;
    checks++;
    if (bus.rsF[31:0] !== 32'hAAAA0000) begin
      errors++;
      $display("FAIL prio_direct: got %h", bus.rsF[31:0]);
    end
    adv(0);
    clr(); prt(0, 5, 1); prt(1, 6, 1);
    stg(0, 5, 0, 1, 32'hAAAA0000); stg(1, 5, 1, 1, 32'h11111111);
    chk("older_rsf0", RSF0, 32'h11111111); chk("older_rsf1", RSF1, 32'h0B0B0B0B);
    adv(0);

    // load-use
    clr(); prt(1, 7, 1); stg(0, 7, 1, 0, 32'h0);
    chk("lu_stall", STALL, 1); chk("lu_rsf1", RSF1, 32'h0B0B0B0B);
    adv(1);
    clr(); prt(1, 7, 1); stg(1, 7, 1, 1, 32'h1234);
    chk("lu_rsf1_fwd", RSF1, 32'h1234); chk("lu_stall_off", STALL, 0); chk_cnt("lu");
    #1;
    checks++;
    if (bus.rsF[63:32] !== 32'h00001234) begin
      errors++;
      $display("FAIL lu_direct: got %h", bus.rsF[63:32]);
    end
    adv(0);
    clr(); prt(1, 7, 1); stg(0, 7, 1, 0, 32'h5555); stg(1, 7, 1, 1, 32'h9999);
    chk("nr_block_stall", STALL, 1); chk("nr_block_rsf1", RSF1, 32'h0B0B0B0B);
    adv(1);

    // scoreboard
    clr(); issueLongDEC = 1'b1; rdDEC = 9;
    chk("sb_issue_stall", STALL, 0); chk("sb_issue_pend", PEND, 0);
    adv(0);
    clr(); prt(0, 9, 1); issueLongDEC = 1'b1; rdDEC = 11;
    chk("sb_pend9", PEND, 32'h200); chk("sb_use_stall", STALL, 1);
    adv(1);
    clr(); prt(0, 9, 0);
    chk("sb_no_set_stalled", PEND, 32'h200); chk("sb_unused_stall", STALL, 0);
    chk("sb_unused_rsf0", RSF0, 32'h0A0A0A0A);
    adv(0);
    clr(); prt(0, 9, 1); doneLong = 1'b1; rdLong = 9; dataLong = 32'hDEAD;
    chk("sb_done_rsf0", RSF0, 32'hDEAD); chk("sb_done_stall", STALL, 0);
    #1;
    checks++;
    if (bus.rsF[31:0] !== 32'h0000DEAD) begin
      errors++;
      $display("FAIL sb_done_direct: got %h", bus.rsF[31:0]);
    end
    adv(0);
    clr(); prt(1, 12, 1); doneLong = 1'b1; rdLong = 12; dataLong = 32'hBEEF;
    chk("sb_cleared", PEND, 0); chk("long_np_rsf1", RSF1, 32'hBEEF);
    adv(0);
    clr(); prt(0, 8, 1); stg(1, 8, 1, 1, 32'h8888); doneLong = 1'b1; rdLong = 8; dataLong = 32'h7777;
    chk("stage_over_long", RSF0, 32'h8888); chk("np_done_pend", PEND, 0);
    adv(0);

    // WAW and simultaneous set/clear
    clr(); issueLongDEC = 1'b1; rdDEC = 3;
    adv(0);
    clr(); issueLongDEC = 1'b1; rdDEC = 3;
    chk("waw_pend", PEND, 32'h8); chk("waw_stall", STALL, 1);
    adv(1);
    clr(); issueLongDEC = 1'b1; rdDEC = 3; doneLong = 1'b1; rdLong = 3;
    chk("waw_done_stall", STALL, 0);
    adv(0);
    clr(); WregDEC = 1'b1; rdDEC = 3;
    chk("set_wins_pend", PEND, 32'h8); chk("waw_wreg_stall", STALL, 1);
    adv(1);
    clr(); doneLong = 1'b1; rdLong = 3; issueLongDEC = 1'b1; rdDEC = 0;
    chk("x0_issue_stall", STALL, 0);
    adv(0);
    clr();
    chk("x0_never_pend", PEND, 0);

    // x0 never forwards
    prt(0, 0, 1); stg(0, 0, 1, 1, 32'hFFFF); doneLong = 1'b1; rdLong = 0; dataLong = 32'h4444;
    chk("x0_rsf0", RSF0, 32'h0A0A0A0A); chk("x0_stall", STALL, 0);
    adv(0);

    // build pending = 0x600, stall up to 40 counts, then reset mid-stall
    clr(); issueLongDEC = 1'b1; rdDEC = 9;
    adv(0);
    clr(); issueLongDEC = 1'b1; rdDEC = 10;
    adv(0);
    clr(); prt(0, 9, 1);
    chk("pend_600", PEND, 32'h600);
    while (cnt32 < 40) begin
      chk("sat_loop_stall", STALL, 1);
      adv(1);
    end
    chk("pre_rst_stall", STALL, 1); chk("pre_rst_pend", PEND, 32'h600); chk_cnt("pre_rst");
    @(negedge clock); #2;
    reset = 1'b1; cnt32 = 0; cnt4 = 0;
    @(posedge clock); #1;
    chk("mid_rst_pend", PEND, 0); chk("mid_rst_stall", STALL, 0); chk_cnt("mid_rst");
    #1;
    checks++;
    if (bus.pending !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst_direct: got %h", bus.pending);
    end
    adv(0);
    reset = 1'b0;

    // 20 stalled cycles saturate the 4-bit counter
    clr(); prt(1, 7, 1); stg(0, 7, 1, 0, 32'h0);
    for (int unsigned i = 0; i < 20; i++) begin
      chk("sat_stall4", STALL4, 1);
      adv(1);
    end
    clr();
    chk("sat_cnt32", CNT, 20); chk("sat_cnt4", CNT4, 15);
    #1;
    checks++;
    if (bus4.stallCount !== 4'hF) begin
      errors++;
      $display("FAIL sat_direct: got %h", bus4.stallCount);
    end
    adv(0);

    for (int unsigned i = 0; i < 5 && q.size() > 0; i++) @(posedge clock);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never sampled, expected %h", e.nm, e.exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
